// File: rtl/bayer_pkg.sv
// Shared definitions for the Bayer front-end: default widths and framing FSM states.
package bayer_pkg;

   localparam int RAW_W      = 10;   // raw sensor pixel width
   localparam int LINE_W_DEF = 640;  // default max active pixels per line
   localparam int ADDR_W_DEF = 10;   // default column/row counter width

   // Framing FSM: wait for FVAL low, then arm for the next FVAL rise.
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ARM   = 2'd1,
      S_FRAME = 2'd2
   } state_t;

endpackage

// File: rtl/bayer_line_ram.sv
// One line of raw pixel storage: simple dual-port, registered read,
// read-before-write on a same-address access.
module bayer_line_ram #(
   parameter int DATA_W = 10,
   parameter int DEPTH  = 640,
   parameter int AW     = 10
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              we,
   input  logic              re,
   input  logic [AW-1:0]     addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   // Storage write; contents are intentionally not reset.
   always_ff @(posedge CLK) begin
      if (we) mem[addr] <= wdata;
   end

   // Read register samples the old word when the same address is written this cycle.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST)     rdata <= '0;
      else if (re) rdata <= mem[addr];
   end

endmodule

// File: rtl/bayer_line_tap.sv
// Two-line tap generator feeding the demosaic: D0 is the current-line pixel,
// D1 the same column one line earlier, with X/Y parity and a DATA_EN qualifier.
//
// Handshake: the sensor stream has no back-pressure. A pixel is accepted on
// every cycle where the FSM is in S_FRAME and FVAL & LVAL are high; the tap
// appears exactly one cycle later with DATA_EN high for that single cycle.
module bayer_line_tap
   import bayer_pkg::*;
#(
   parameter int DATA_W = RAW_W,
   parameter int LINE_W = LINE_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              FVAL,
   input  logic              LVAL,
   input  logic [DATA_W-1:0] IN_DATA,
   output logic [DATA_W-1:0] D0,
   output logic [DATA_W-1:0] D1,
   output logic              X,
   output logic              Y,
   output logic              DATA_EN,
   output logic              OVF,
   output state_t            STATE
);

   localparam int RAM_AW = (LINE_W > 1) ? $clog2(LINE_W) : 1;
   localparam logic [ADDR_W-1:0] COL_MAX = ADDR_W'(LINE_W);

   state_t              state, state_nxt;
   logic                fval_q;
   logic                in_line;
   logic                first_row;
   logic                d1_zero;
   logic [ADDR_W-1:0]   col, row;
   logic [DATA_W-1:0]   ram_q;
   logic                acc, frame_start, line_end, col_full, ram_en;

   assign acc         = (state == S_FRAME) && FVAL && LVAL;
   assign frame_start = (state == S_ARM) && !fval_q && FVAL;
   // Line closes on LVAL fall or on FVAL dropping mid-line.
   assign line_end    = (state == S_FRAME) && in_line && !acc;
   assign col_full    = (col == COL_MAX);
   assign ram_en      = acc && !col_full;
   assign STATE       = state;
   // The read register holds the previous line; first row and overflow pixels force zero.
   assign D1          = d1_zero ? '0 : ram_q;

   bayer_line_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (LINE_W),
      .AW     (RAM_AW)
   ) u_line_ram (
      .CLK   (CLK),
      .RST   (RST),
      .we    (ram_en),
      .re    (ram_en),
      .addr  (col[RAM_AW-1:0]),
      .wdata (IN_DATA),
      .rdata (ram_q)
   );

   // Framing state register.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // Next-state: never join a frame already in progress.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (!FVAL)      state_nxt = S_ARM;
         S_ARM:   if (frame_start) state_nxt = S_FRAME;
         S_FRAME: if (!FVAL)      state_nxt = S_ARM;
         default:                 state_nxt = S_IDLE;
      endcase
   end

   // Column/row counters and line bookkeeping; held between frames.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         fval_q    <= 1'b0;
         in_line   <= 1'b0;
         first_row <= 1'b1;
         col       <= '0;
         row       <= '0;
      end else begin
         fval_q <= FVAL;
         if (frame_start) begin
            in_line   <= 1'b0;
            first_row <= 1'b1;
            col       <= '0;
            row       <= '0;
         end else begin
            in_line <= acc;
            if (acc) begin
               if (!col_full) col <= col + 1'b1;
            end else if (line_end) begin
               col       <= '0;
               row       <= row + 1'b1;
               first_row <= 1'b0;
            end
         end
      end
   end

   // Output registers: capture on accept, hold otherwise; OVF sticky per frame.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         D0      <= '0;
         X       <= 1'b0;
         Y       <= 1'b0;
         DATA_EN <= 1'b0;
         OVF     <= 1'b0;
         d1_zero <= 1'b1;
      end else begin
         DATA_EN <= acc;
         if (frame_start) OVF <= 1'b0;
         if (acc) begin
            D0      <= IN_DATA;
            X       <= col[0];
            Y       <= row[0];
            d1_zero <= first_row || col_full;
            if (col_full) OVF <= 1'b1;
         end
      end
   end

endmodule
